// File: rtl/switch_pkg.sv
// Shared types for the 4-port switch: port count, port index type and arbiter state encoding.
package switch_pkg;
  localparam int NUM_PORTS = 4;
  localparam int SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [SEL_W-1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/output_arbiter_if.sv
// Arbiter <-> input FIFOs / output mux bundle for one output port of the switch.
interface output_arbiter_if;
  import switch_pkg::*;

  // Handshake: req[i] is the valid of FIFO i's head flit, out_ready the downstream ready;
  // a flit transfers (pop) only in a cycle where arb_active & out_ready, and the head flit
  // of the granted FIFO must stay unchanged until that cycle.
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] eop;
  logic                 out_ready;
  port_idx_t            mux_sel;
  logic                 arb_active;
  logic [NUM_PORTS-1:0] pop;
  logic                 pkt_done;
  logic                 wd_err;

  modport master (
    input  req, eop, out_ready,
    output mux_sel, arb_active, pop, pkt_done, wd_err
  );

  modport slave (
    output req, eop, out_ready,
    input  mux_sel, arb_active, pop, pkt_done, wd_err
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester after rr_ptr, wrapping modulo NUM_PORTS.
module rr_priority_pick
  import switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            rr_ptr,
  output port_idx_t            winner,
  output logic                 any_req
);

  // Scan farthest-to-nearest so the nearest requester after rr_ptr is the last write.
  always_comb begin
    winner = rr_ptr;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        winner = port_idx_t'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/output_arbiter.sv
// Packet-locked round-robin arbiter for one switch output port.
// Optional watchdog release enabled by defining ARB_WATCHDOG_EN.
module output_arbiter
  import switch_pkg::*;
#(
  parameter int MAX_PKT_FLITS = 64,
  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output_arbiter_if.master  bus,
  output arb_state_t        state_dbg,
  output logic [CNT_W-1:0]  flit_cnt_dbg
);

  arb_state_t           state;
  port_idx_t            mux_sel;
  port_idx_t            rr_ptr;
  port_idx_t            winner;
  logic                 any_req;
  logic [CNT_W-1:0]     flit_cnt;
  logic                 head_req;
  logic                 pop_any;
  logic                 eop_pop;
  logic [NUM_PORTS-1:0] pop_vec;
`ifdef ARB_WATCHDOG_EN
  logic                 wd_err;
  logic                 wd_fire;
`endif

  rr_priority_pick u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    head_req         = bus.req[mux_sel];
    pop_any          = (state == BUSY) & head_req & bus.out_ready;
    eop_pop          = pop_any & bus.eop[mux_sel];
    pop_vec          = '0;
    pop_vec[mux_sel] = pop_any;
  end

`ifdef ARB_WATCHDOG_EN
  // Fires on the pop that brings the count to the limit without closing the packet.
  assign wd_fire = pop_any & ~bus.eop[mux_sel] & (flit_cnt == CNT_W'(MAX_PKT_FLITS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mux_sel  <= '0;
      rr_ptr   <= port_idx_t'(NUM_PORTS - 1);
      flit_cnt <= '0;
`ifdef ARB_WATCHDOG_EN
      wd_err   <= 1'b0;
`endif
    end else begin
`ifdef ARB_WATCHDOG_EN
      wd_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            mux_sel  <= winner;
            flit_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (pop_any && (flit_cnt != CNT_W'(MAX_PKT_FLITS))) begin
            flit_cnt <= flit_cnt + 1'b1;
          end
          // Leaving BUSY always costs one IDLE cycle before the next grant.
          if (eop_pop) begin
            rr_ptr <= mux_sel;
            state  <= IDLE;
          end
`ifdef ARB_WATCHDOG_EN
          else if (wd_fire) begin
            wd_err <= 1'b1;
            rr_ptr <= mux_sel;
            state  <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mux_sel    = mux_sel;
  assign bus.arb_active = (state == BUSY) & head_req;
  assign bus.pop        = pop_vec;
  assign bus.pkt_done   = eop_pop;
`ifdef ARB_WATCHDOG_EN
  assign bus.wd_err     = wd_err;
`else
  assign bus.wd_err     = 1'b0;
`endif

  assign state_dbg    = state;
  assign flit_cnt_dbg = flit_cnt;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: vector table for round-robin rotation plus hand sequences.
module tb_output_arbiter;
  import switch_pkg::*;

  localparam int MAXF  = 4;
  localparam int CW    = $clog2(MAXF + 1);

  typedef struct {
    logic [3:0] req;
    logic [3:0] eop;
    logic       rdy;
    logic [1:0] sel;
    logic       act;
    logic [3:0] pop;
    logic       done;
  } vec_t;

  logic          clk;
  logic          rst_n;
  arb_state_t    state_dbg;
  logic [CW-1:0] flit_cnt_dbg;
  int            pass_cnt;
  int            total_cnt;
  vec_t          tbl[12];

  output_arbiter_if bus_if ();

  output_arbiter #(.MAX_PKT_FLITS(MAXF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .state_dbg    (state_dbg),
    .flit_cnt_dbg (flit_cnt_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the next rising edge.
  task automatic apply(input logic [3:0] r, input logic [3:0] e, input logic rdy,
                       input logic [1:0] sel, input logic act, input logic [3:0] p,
                       input logic done, input logic wd, input string tag);
    bus_if.req       = r;
    bus_if.eop       = e;
    bus_if.out_ready = rdy;
    @(negedge clk);
    chk({tag, " mux_sel"},    32'(bus_if.mux_sel),    32'(sel));
    chk({tag, " arb_active"}, 32'(bus_if.arb_active), 32'(act));
    chk({tag, " pop"},        32'(bus_if.pop),        32'(p));
    chk({tag, " pkt_done"},   32'(bus_if.pkt_done),   32'(done));
    chk({tag, " wd_err"},     32'(bus_if.wd_err),     32'(wd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // All four ports hold single-flit packets: expect grants 0,1,2,3,0 with an idle cycle between.
    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1};
    tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1};
    tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0};
    tbl[10] = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};

    // Reset
    rst_n            = 1'b0;
    bus_if.req       = '0;
    bus_if.eop       = '0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mux_sel",    32'(bus_if.mux_sel),    32'd0);
    chk("reset arb_active", 32'(bus_if.arb_active), 32'd0);
    chk("reset pop",        32'(bus_if.pop),        32'd0);
    chk("reset pkt_done",   32'(bus_if.pkt_done),   32'd0);
    chk("reset wd_err",     32'(bus_if.wd_err),     32'd0);
    chk("reset state",      32'(state_dbg),         32'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].req, tbl[i].eop, tbl[i].rdy, tbl[i].sel, tbl[i].act, tbl[i].pop,
            tbl[i].done, 1'b0, $sformatf("rr[%0d]", i));
    end
    chk("idle after table state", 32'(state_dbg), 32'(IDLE));

    // Port 2 sends 3 flits; port 0 requests during flit 2 and must wait for the EOP.
    apply(4'b0100, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, "lock a0");
    apply(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, "lock a1");
    apply(4'b0101, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, "lock a2");
    apply(4'b0101, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, "lock a3");
    chk("lock flit_cnt", 32'(flit_cnt_dbg), 32'd3);
    chk("lock state",    32'(state_dbg),    32'(IDLE));
    apply(4'b0001, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, "lock a4");
    apply(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, "lock a5");

    // Downstream stall for 5 cycles mid-packet on port 1.
    apply(4'b0010, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, "stall b0");
    apply(4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, "stall b1");
    for (int i = 0; i < 5; i++) begin
      apply(4'b0011, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0, $sformatf("stall hold%0d", i));
    end
    apply(4'b0011, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0, "stall b7");
    chk("stall flit_cnt", 32'(flit_cnt_dbg), 32'd2);

    // Port 1 underruns for 2 cycles while ports 0 and 3 request.
    apply(4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0, "under c0");
    apply(4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, "under c1");
    apply(4'b1001, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0, "under c2");
    apply(4'b1001, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0, "under c3");
    chk("under state", 32'(state_dbg), 32'(BUSY));
    apply(4'b1011, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0, "under c4");
    apply(4'b1001, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0, "under c5");
    apply(4'b1001, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, "under c6");

    // Single-flit from port 0 moves rr_ptr to 0, then reset lands in the middle of a port-2 packet.
    apply(4'b0001, 4'b0001, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0, "rst d0");
    apply(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, "rst d1");
    apply(4'b0100, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, "rst d2");
    apply(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, "rst d3");
    rst_n = 1'b0;
    #1;
    chk("midrst mux_sel",    32'(bus_if.mux_sel),    32'd0);
    chk("midrst arb_active", 32'(bus_if.arb_active), 32'd0);
    chk("midrst pop",        32'(bus_if.pop),        32'd0);
    chk("midrst state",      32'(state_dbg),         32'(IDLE));
    chk("midrst flit_cnt",   32'(flit_cnt_dbg),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // rr_ptr back at 3 means port 0 wins over port 1, and port 2's partial packet is dropped.
    apply(4'b0011, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, "rst d4");
    apply(4'b0011, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, "rst d5");

    // Long packet on port 2 (no EOP for 6 flits) against the flit limit.
    apply(4'b0100, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, "long e0");
`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 4; i++) begin
      apply(4'b0101, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, $sformatf("wd pop%0d", i));
    end
    chk("wd state after 4th pop", 32'(state_dbg), 32'(IDLE));
    apply(4'b0101, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1, "wd release");
    apply(4'b0101, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, "wd next port");
`else
    for (int i = 0; i < 6; i++) begin
      apply(4'b0101, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, $sformatf("long pop%0d", i));
    end
    chk("long flit_cnt sat", 32'(flit_cnt_dbg), 32'(MAXF));
    chk("long state",        32'(state_dbg),    32'(BUSY));
    apply(4'b0101, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, "long eop");
    apply(4'b0001, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, "long e8");
    apply(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, "long e9");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
